// File: rtl/hybrid_branch_predictor_pkg.sv
// Shared types and helpers for the hybrid (local/global/chooser) branch predictor.
// Every 2-bit counter table uses the same saturating next-value function.
package hybrid_branch_predictor_pkg;

    typedef logic [1:0] ctr2_t;

    localparam ctr2_t SNT = 2'b00;
    localparam ctr2_t WNT = 2'b01;
    localparam ctr2_t WT  = 2'b10;
    localparam ctr2_t ST  = 2'b11;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } bp_state_t;

    function automatic ctr2_t ctr_next(input ctr2_t c, input logic up);
        if (up) begin
            return (c == ST) ? ST : ctr2_t'(c + 2'd1);
        end
        return (c == SNT) ? SNT : ctr2_t'(c - 2'd1);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/hybrid_branch_predictor_if.sv
// Fetch-side lookup and execute-side update bundle for the branch predictor.
// The master is the pipeline; the slave is the predictor.
interface hybrid_branch_predictor_if #(
    parameter int GS = 6
);
    logic          ready;

    logic          lookup_valid;
    logic [15:0]   lookup_pc;
    logic          pred_taken;
    logic [15:0]   pred_target;
    logic          pred_local;
    logic          pred_global;
    logic          pred_sel;
    logic [GS-1:0] pred_ghist;

    logic          update_valid;
    logic [15:0]   update_pc;
    logic [15:0]   update_target;
    logic          update_taken;
    logic          update_mispredict;
    logic [GS-1:0] update_ghist;
    logic          update_local;
    logic          update_global;

    modport master (
        input  ready, pred_taken, pred_target, pred_local, pred_global, pred_sel, pred_ghist,
        output lookup_valid, lookup_pc,
        output update_valid, update_pc, update_target, update_taken, update_mispredict,
        output update_ghist, update_local, update_global
    );

    modport slave (
        output ready, pred_taken, pred_target, pred_local, pred_global, pred_sel, pred_ghist,
        input  lookup_valid, lookup_pc,
        input  update_valid, update_pc, update_target, update_taken, update_mispredict,
        input  update_ghist, update_local, update_global
    );

endinterface

// File: rtl/hybrid_branch_predictor_btb.sv
// Direct-mapped branch target buffer: combinational read, one write port and a
// clear port used by the predictor's initialisation walk to invalidate entries.
module hybrid_branch_predictor_btb #(
    parameter int ENTRIES = 16
) (
    input  logic                       i_clk,
    input  logic [15:0]                i_rd_pc,
    output logic                       o_rd_hit,
    output logic [15:0]                o_rd_target,
    input  logic                       i_wr_en,
    input  logic [15:0]                i_wr_pc,
    input  logic [15:0]                i_wr_target,
    input  logic                       i_clr_en,
    input  logic [$clog2(ENTRIES)-1:0] i_clr_idx
);
    localparam int IW = $clog2(ENTRIES);
    localparam int TW = 15 - IW;

    logic [TW-1:0]      r_tag [ENTRIES];
    logic [15:0]        r_tgt [ENTRIES];
    logic [ENTRIES-1:0] r_valid;
    logic [ENTRIES-1:0] w_valid_next;

    logic [IW-1:0] w_rd_idx;
    logic [IW-1:0] w_wr_idx;
    logic [TW-1:0] w_rd_tag;
    logic [TW-1:0] w_wr_tag;
    logic          w_unused_bits;

    // Bit 0 of a halfword-aligned pc carries no information.
    assign w_unused_bits = ^{i_rd_pc[0], i_wr_pc[0]};

    assign w_rd_idx = i_rd_pc[IW:1];
    assign w_rd_tag = i_rd_pc[15:IW+1];
    assign w_wr_idx = i_wr_pc[IW:1];
    assign w_wr_tag = i_wr_pc[15:IW+1];

    assign o_rd_hit    = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
    assign o_rd_target = r_tgt[w_rd_idx];

    always_ff @(posedge i_clk) begin
        if (i_wr_en && !i_clr_en) begin
            r_tag[w_wr_idx] <= w_wr_tag;
            r_tgt[w_wr_idx] <= i_wr_target;
        end
    end

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_valid
            assign w_valid_next[gi] = (i_clr_en && (i_clr_idx == IW'(gi))) ? 1'b0 :
                                      (i_wr_en  && (w_wr_idx  == IW'(gi))) ? 1'b1 :
                                      r_valid[gi];
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        r_valid <= w_valid_next;
    end

endmodule

// File: rtl/hybrid_branch_predictor.sv
// Tournament predictor: per-pc local counters, gshare global counters, a per-pc
// chooser and a BTB; tables are walked to known values after every reset.
module hybrid_branch_predictor
    import hybrid_branch_predictor_pkg::*;
#(
    parameter int LS          = 8,
    parameter int GS          = 6,
    parameter int BTB_ENTRIES = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    hybrid_branch_predictor_if.slave   bp
);
    localparam int LN = 1 << LS;
    localparam int GN = 1 << GS;
    localparam int N  = max3(LN, GN, BTB_ENTRIES);
    localparam int NW = (N > 1) ? $clog2(N) : 1;
    localparam int BW = $clog2(BTB_ENTRIES);

    ctr2_t r_local_tbl   [LN];
    ctr2_t r_global_tbl  [GN];
    ctr2_t r_chooser_tbl [LN];

    bp_state_t     r_state;
    bp_state_t     w_state_next;
    logic [NW-1:0] r_idx;
    logic [NW-1:0] w_idx_next;
    logic [GS-1:0] r_ghist;

    logic w_init;
    logic w_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_INIT;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_init       = 1'b0;
        w_ready      = 1'b0;
        if (r_state == S_INIT) begin
            w_init = 1'b1;
            if (r_idx == NW'(N - 1)) begin
                w_state_next = S_RUN;
                w_idx_next   = '0;
            end else begin
                w_idx_next = r_idx + NW'(1);
            end
        end else begin
            w_ready = 1'b1;
        end
    end

    // ---------------- lookup ----------------
    logic [LS-1:0] w_lk_lidx;
    logic [GS-1:0] w_lk_gidx;
    logic          w_lk_local;
    logic          w_lk_global;
    logic          w_lk_sel;
    logic          w_lk_dir;
    logic          w_btb_hit;
    logic [15:0]   w_btb_target;
    logic          w_pred_taken;

    assign w_lk_lidx   = bp.lookup_pc[LS:1];
    assign w_lk_gidx   = r_ghist ^ bp.lookup_pc[GS:1];
    assign w_lk_local  = r_local_tbl[w_lk_lidx][1];
    assign w_lk_global = r_global_tbl[w_lk_gidx][1];
    assign w_lk_sel    = r_chooser_tbl[w_lk_lidx][1];
    assign w_lk_dir    = w_lk_sel ? w_lk_global : w_lk_local;

    // Everything table-derived is masked until the walk finishes so stale
    // contents from before a reset can never leak out.
    assign w_pred_taken   = w_ready && w_btb_hit && w_lk_dir;
    assign bp.ready       = w_ready;
    assign bp.pred_taken  = w_pred_taken;
    assign bp.pred_target = (w_ready && w_btb_hit) ? w_btb_target : (bp.lookup_pc + 16'd2);
    assign bp.pred_local  = w_ready && w_lk_local;
    assign bp.pred_global = w_ready && w_lk_global;
    assign bp.pred_sel    = w_ready && w_lk_sel;
    assign bp.pred_ghist  = r_ghist;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ghist <= '0;
        end else if (w_init) begin
            r_ghist <= '0;
        end else if (bp.update_valid && bp.update_mispredict) begin
            r_ghist <= {bp.update_ghist[GS-2:0], bp.update_taken};
        end else if (bp.lookup_valid) begin
            r_ghist <= {r_ghist[GS-2:0], w_pred_taken};
        end
    end

    // ---------------- update / init write ports ----------------
    logic          w_upd;
    logic [LS-1:0] w_up_lidx;
    logic [GS-1:0] w_up_gidx;
    logic          w_init_l;
    logic          w_init_g;
    logic          w_init_b;
    logic          w_glob_right;

    assign w_upd        = w_ready && bp.update_valid;
    assign w_up_lidx    = bp.update_pc[LS:1];
    assign w_up_gidx    = bp.update_ghist ^ bp.update_pc[GS:1];
    assign w_init_l     = w_init && (int'(r_idx) < LN);
    assign w_init_g     = w_init && (int'(r_idx) < GN);
    assign w_init_b     = w_init && (int'(r_idx) < BTB_ENTRIES);
    assign w_glob_right = (bp.update_global == bp.update_taken);

    logic          w_lc_we;
    logic [LS-1:0] w_lc_addr;
    ctr2_t         w_lc_data;
    logic          w_gc_we;
    logic [GS-1:0] w_gc_addr;
    ctr2_t         w_gc_data;
    logic          w_ch_we;
    logic [LS-1:0] w_ch_addr;
    ctr2_t         w_ch_data;

    always_comb begin
        w_lc_we   = w_upd;
        w_lc_addr = w_up_lidx;
        w_lc_data = ctr_next(r_local_tbl[w_up_lidx], bp.update_taken);
        w_gc_we   = w_upd;
        w_gc_addr = w_up_gidx;
        w_gc_data = ctr_next(r_global_tbl[w_up_gidx], bp.update_taken);
        w_ch_we   = w_upd && (bp.update_local != bp.update_global);
        w_ch_addr = w_up_lidx;
        w_ch_data = ctr_next(r_chooser_tbl[w_up_lidx], w_glob_right);
        if (w_init) begin
            w_lc_we   = w_init_l;
            w_lc_addr = r_idx[LS-1:0];
            w_lc_data = WNT;
            w_gc_we   = w_init_g;
            w_gc_addr = r_idx[GS-1:0];
            w_gc_data = WNT;
            w_ch_we   = w_init_l;
            w_ch_addr = r_idx[LS-1:0];
            w_ch_data = WNT;
        end
    end

    always_ff @(posedge clk) begin
        if (w_lc_we) r_local_tbl[w_lc_addr] <= w_lc_data;
    end

    always_ff @(posedge clk) begin
        if (w_gc_we) r_global_tbl[w_gc_addr] <= w_gc_data;
    end

    always_ff @(posedge clk) begin
        if (w_ch_we) r_chooser_tbl[w_ch_addr] <= w_ch_data;
    end

    hybrid_branch_predictor_btb #(
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .i_clk       (clk),
        .i_rd_pc     (bp.lookup_pc),
        .o_rd_hit    (w_btb_hit),
        .o_rd_target (w_btb_target),
        .i_wr_en     (w_upd && bp.update_taken),
        .i_wr_pc     (bp.update_pc),
        .i_wr_target (bp.update_target),
        .i_clr_en    (w_init_b),
        .i_clr_idx   (r_idx[BW-1:0])
    );

endmodule

// File: tb/tb_hybrid_branch_predictor.sv
// Randomised and directed checks of hybrid_branch_predictor against a
// table-level reference model using plain integer arithmetic.
module tb_hybrid_branch_predictor;

    localparam int LN  = 256;
    localparam int GN  = 64;
    localparam int BN  = 16;

    logic clk;
    logic reset_n;

    hybrid_branch_predictor_if #(.GS(6)) bp_if ();

    hybrid_branch_predictor #(
        .LS          (8),
        .GS          (6),
        .BTB_ENTRIES (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bp      (bp_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests;
    int n_fail;

    // Reference model state
    int m_loc [LN];
    int m_glb [GN];
    int m_cho [LN];
    bit m_bv  [BN];
    int m_bpc [BN];
    int m_btg [BN];
    int m_ghist;

    // Last observed outputs from do_cycle
    logic        obs_taken;
    logic [15:0] obs_target;
    logic        obs_local;
    logic        obs_global;
    logic        obs_sel;
    logic [5:0]  obs_ghist;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < LN; i++) begin
            m_loc[i] = 1;
            m_cho[i] = 1;
        end
        for (int i = 0; i < GN; i++) m_glb[i] = 1;
        for (int i = 0; i < BN; i++) begin
            m_bv[i]  = 1'b0;
            m_bpc[i] = 0;
            m_btg[i] = 0;
        end
        m_ghist = 0;
    endtask

    function automatic int sat(input int v);
        return (v > 3) ? 3 : ((v < 0) ? 0 : v);
    endfunction

    task automatic drive_idle();
        bp_if.lookup_valid      = 1'b0;
        bp_if.lookup_pc         = 16'h0;
        bp_if.update_valid      = 1'b0;
        bp_if.update_pc         = 16'h0;
        bp_if.update_target     = 16'h0;
        bp_if.update_taken      = 1'b0;
        bp_if.update_mispredict = 1'b0;
        bp_if.update_ghist      = 6'h0;
        bp_if.update_local      = 1'b0;
        bp_if.update_global     = 1'b0;
    endtask

    task automatic do_cycle(input bit lv, input logic [15:0] lpc, input bit uv,
                            input logic [15:0] upc, input logic [15:0] utgt,
                            input bit ut, input bit um, input logic [5:0] ugh,
                            input bit ul, input bit ug);
        int pc, lidx, gidx, bidx, e_tgt, upi, uli, ugi, ubi, step;
        bit e_l, e_g, e_sel, e_dir, e_hit, e_taken;
        @(negedge clk);
        bp_if.lookup_valid      = lv;
        bp_if.lookup_pc         = lpc;
        bp_if.update_valid      = uv;
        bp_if.update_pc         = upc;
        bp_if.update_target     = utgt;
        bp_if.update_taken      = ut;
        bp_if.update_mispredict = um;
        bp_if.update_ghist      = ugh;
        bp_if.update_local      = ul;
        bp_if.update_global     = ug;
        #1;
        pc      = int'(lpc);
        lidx    = (pc >> 1) % LN;
        gidx    = (m_ghist ^ (pc >> 1)) % GN;
        bidx    = (pc >> 1) % BN;
        e_l     = (m_loc[lidx] >= 2);
        e_g     = (m_glb[gidx] >= 2);
        e_sel   = (m_cho[lidx] >= 2);
        e_dir   = e_sel ? e_g : e_l;
        e_hit   = m_bv[bidx] && ((m_bpc[bidx] >> 5) == (pc >> 5));
        e_taken = e_hit && e_dir;
        e_tgt   = e_hit ? m_btg[bidx] : ((pc + 2) % 65536);

        obs_taken  = bp_if.pred_taken;
        obs_target = bp_if.pred_target;
        obs_local  = bp_if.pred_local;
        obs_global = bp_if.pred_global;
        obs_sel    = bp_if.pred_sel;
        obs_ghist  = bp_if.pred_ghist;

        check_eq("ready",       32'(bp_if.ready), 32'd1);
        check_eq("pred_taken",  32'(obs_taken),  32'(e_taken));
        check_eq("pred_target", 32'(obs_target), 32'(e_tgt));
        check_eq("pred_local",  32'(obs_local),  32'(e_l));
        check_eq("pred_global", 32'(obs_global), 32'(e_g));
        check_eq("pred_sel",    32'(obs_sel),    32'(e_sel));
        check_eq("pred_ghist",  32'(obs_ghist),  32'(m_ghist));
        $display("[TB] t=%0t lk=%0b pc=%h upd=%0b upc=%h t=%0b mp=%0b -> taken=%0b tgt=%h sel=%0b gh=%h",
                 $time, lv, lpc, uv, upc, ut, um, obs_taken, obs_target, obs_sel, obs_ghist);

        @(posedge clk);
        if (uv) begin
            upi  = int'(upc);
            uli  = (upi >> 1) % LN;
            ugi  = (int'(ugh) ^ (upi >> 1)) % GN;
            ubi  = (upi >> 1) % BN;
            step = ut ? 1 : -1;
            m_loc[uli] = sat(m_loc[uli] + step);
            m_glb[ugi] = sat(m_glb[ugi] + step);
            if (ul != ug) m_cho[uli] = sat(m_cho[uli] + ((ug == ut) ? 1 : -1));
            if (ut) begin
                m_bv[ubi]  = 1'b1;
                m_bpc[ubi] = upi;
                m_btg[ubi] = int'(utgt);
            end
        end
        if (uv && um)  m_ghist = ((int'(ugh) << 1) | int'(ut)) % GN;
        else if (lv)   m_ghist = ((m_ghist << 1) | int'(e_taken)) % GN;
    endtask

    // Waits for ready while hammering the predictor with traffic that must be ignored.
    task automatic wait_ready(output int cyc);
        cyc = 0;
        bp_if.lookup_valid      = 1'b1;
        bp_if.lookup_pc         = 16'h3000;
        bp_if.update_valid      = 1'b1;
        bp_if.update_pc         = 16'h3000;
        bp_if.update_target     = 16'h3040;
        bp_if.update_taken      = 1'b1;
        bp_if.update_mispredict = 1'b1;
        bp_if.update_ghist      = 6'h2A;
        bp_if.update_local      = 1'b0;
        bp_if.update_global     = 1'b1;
        while (cyc < 1000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 100) begin
                check_eq("init_taken",  32'(bp_if.pred_taken),  32'd0);
                check_eq("init_target", 32'(bp_if.pred_target), 32'h3002);
                check_eq("init_ghist",  32'(bp_if.pred_ghist),  32'd0);
            end
            if (bp_if.ready) break;
        end
        drive_idle();
    endtask

    logic [15:0] pool [8];

    initial begin
        int cyc;
        logic [15:0] pc_a, pc_b;
        n_tests = 0;
        n_fail  = 0;
        pool[0] = 16'h3000; pool[1] = 16'h1234; pool[2] = 16'h2468; pool[3] = 16'h0100;
        pool[4] = 16'h3010; pool[5] = 16'h5000; pool[6] = 16'h0ABC; pool[7] = 16'hFFFE;
        reset_n = 1'b0;
        drive_idle();
        m_reset();

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", 32'(bp_if.ready),      32'd0);
        check_eq("rst_taken", 32'(bp_if.pred_taken), 32'd0);
        check_eq("rst_ghist", 32'(bp_if.pred_ghist), 32'd0);

        @(negedge clk);
        reset_n = 1'b1;
        wait_ready(cyc);
        check_eq("init_cycles", 32'(cyc), 32'd256);

        do_cycle(1, 16'h0400, 0, 16'h0, 16'h0, 0, 0, 6'h0, 0, 0);
        check_eq("first_taken",  32'(obs_taken),  32'd0);
        check_eq("first_target", 32'(obs_target), 32'h0402);

        // Four taken updates then a lookup hit
        repeat (4) do_cycle(0, 16'h0, 1, 16'h3000, 16'h3040, 1, 0, 6'h0, 0, 0);
        do_cycle(1, 16'h3000, 0, 16'h0, 16'h0, 0, 0, 6'h0, 0, 0);
        check_eq("r037_taken",  32'(obs_taken),  32'd1);
        check_eq("r037_target", 32'(obs_target), 32'h3040);
        check_eq("r037_local",  32'(obs_local),  32'd1);

        // Saturation at strongly taken, then a single step down
        repeat (2) do_cycle(0, 16'h0, 1, 16'h3000, 16'h3040, 1, 0, 6'h0, 0, 0);
        do_cycle(0, 16'h0, 1, 16'h3000, 16'h3040, 0, 0, 6'h0, 0, 0);
        do_cycle(1, 16'h3000, 0, 16'h0, 16'h0, 0, 0, 6'h0, 0, 0);
        check_eq("r038_taken", 32'(obs_taken), 32'd1);
        do_cycle(0, 16'h0, 1, 16'h3000, 16'h3040, 0, 0, 6'h0, 0, 0);
        do_cycle(0, 16'h3000, 0, 16'h0, 16'h0, 0, 0, 6'h0, 0, 0);
        check_eq("r038_local_nt", 32'(obs_local), 32'd0);

        // Mispredict repair beats a same-cycle speculative shift
        do_cycle(0, 16'h0, 1, 16'h1234, 16'h1300, 1, 1, 6'h0A, 0, 0);
        do_cycle(1, 16'h1234, 1, 16'h1234, 16'h1300, 1, 1, 6'h0A, 0, 0);
        check_eq("r039_gh_before", 32'(obs_ghist), 32'h15);
        do_cycle(0, 16'h0, 0, 16'h0, 16'h0, 0, 0, 6'h0, 0, 0);
        check_eq("r039_gh_after", 32'(obs_ghist), 32'h15);

        // Chooser trained toward global
        repeat (2) do_cycle(0, 16'h0, 1, 16'h2468, 16'h2500, 1, 0, 6'h0, 0, 1);
        do_cycle(0, 16'h2468, 0, 16'h0, 16'h0, 0, 0, 6'h0, 0, 0);
        check_eq("r040_sel", 32'(obs_sel), 32'd1);

        // Randomised traffic over a small pc pool (includes BTB aliasing and pc wrap)
        for (int k = 0; k < 400; k++) begin
            pc_a = pool[$urandom_range(0, 7)];
            pc_b = pool[$urandom_range(0, 7)];
            do_cycle($urandom_range(0, 1) == 1, pc_a,
                     $urandom_range(0, 2) != 0, pc_b, 16'($urandom_range(0, 65535)) & 16'hFFFE,
                     $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
                     6'($urandom_range(0, 63)),
                     $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        // Make 0x3000 a known hit, then reset asynchronously mid-cycle
        repeat (3) do_cycle(0, 16'h0, 1, 16'h3000, 16'h3040, 1, 0, 6'h0, 0, 0);
        bp_if.lookup_pc = 16'h3000;
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("async_ready", 32'(bp_if.ready),      32'd0);
        check_eq("async_taken", 32'(bp_if.pred_taken), 32'd0);
        check_eq("async_ghist", 32'(bp_if.pred_ghist), 32'd0);
        #10;
        reset_n = 1'b1;
        m_reset();
        wait_ready(cyc);
        check_eq("reinit_cycles", 32'(cyc), 32'd256);
        do_cycle(1, 16'h3000, 0, 16'h0, 16'h0, 0, 0, 6'h0, 0, 0);
        check_eq("r041_taken",  32'(obs_taken),  32'd0);
        check_eq("r041_target", 32'(obs_target), 32'h3002);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hybrid_branch_predictor.md
HYBRID_BRANCH_PREDICTOR -- requirements
Module: hybrid_branch_predictor

Interface
REQ-001 Parameter LS, default 8: local/chooser index bits; tables hold 2^LS entries indexed by pc[LS:1].
REQ-002 Parameter GS, default 6: global history bits; global table holds 2^GS entries.
REQ-003 Parameter BTB_ENTRIES, default 16, power of two: direct-mapped BTB depth.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 ready  out  1  tables initialised; predictor usable.
REQ-007 lookup_valid  in  1  fetch is issuing lookup_pc this cycle.
REQ-008 lookup_pc  in  16  fetch address.
REQ-009 pred_taken  out  1  predicted taken (combinational from lookup_pc).
REQ-010 pred_target  out  16  BTB target for lookup_pc.
REQ-011 pred_local, pred_global  out  1 each  component direction predictions.
REQ-012 pred_sel  out  1  chooser choice: 1 = global.
REQ-013 pred_ghist  out  GS  global history used for this lookup.
REQ-014 update_valid  in  1  resolved conditional branch.
REQ-015 update_pc, update_target  in  16 each  resolved branch address and target.
REQ-016 update_taken, update_mispredict  in  1 each  actual outcome; prediction was wrong.
REQ-017 update_ghist  in  GS; update_local, update_global  in  1 each: metadata returned from lookup.

Function
REQ-018 FSM states INIT and RUN; INIT walks counter i from 0 to N-1, N = max(2^LS, 2^GS, BTB_ENTRIES), one entry per cycle, then enters RUN; ready = (state == RUN).
REQ-019 INIT writes local/global counters to 01 (weakly not taken), chooser to 01 (weakly local), BTB valid to 0; indices beyond a table's size are ignored.
REQ-020 In INIT, pred_taken = 0, ghist holds 0, and updates and lookups are ignored.
REQ-021 Local index = lookup_pc[LS:1]; global index = ghist XOR lookup_pc[GS:1]; pred_local/pred_global = MSB of addressed counter.
REQ-022 pred_sel = chooser[1]; direction = pred_sel ? pred_global : pred_local.
REQ-023 BTB index = pc[log2(BTB_ENTRIES):1]; tag = remaining upper bits of pc[15:1]; hit = valid and tag match.
REQ-024 pred_taken = ready AND hit AND direction; pred_target = stored target on hit, else lookup_pc + 2.
REQ-025 Speculative ghist: on lookup_valid in RUN, ghist <= {ghist[GS-2:0], pred_taken}.
REQ-026 On update_valid AND update_mispredict, ghist <= {update_ghist[GS-2:0], update_taken}; takes priority over a same-cycle lookup shift.
REQ-027 On update_valid, local counter at update_pc[LS:1] and global counter at update_ghist XOR update_pc[GS:1] saturate: +1 max 11 if taken, -1 min 00 if not.
REQ-028 Chooser at update_pc[LS:1] updates only if update_local != update_global: +1 (sat 11) if global was correct, else -1 (sat 00).
REQ-029 On update_valid AND update_taken, BTB entry written: valid=1, tag, update_target; not-taken updates never evict.
REQ-030 Same-cycle lookup and update to one entry: lookup sees pre-update value (read-before-write).

Reset
REQ-031 reset_n low: state = INIT, i = 0, ghist = 0, ready = 0, pred_taken = 0, at once, without waiting for clk.
REQ-032 reset_n asserted mid-INIT or mid-RUN restarts INIT from i = 0; stale table contents never observable while ready = 0.

Structure
REQ-033 lc3b_types gains 2-bit counter typedef and constants SNT=00, WNT=01, WT=10, ST=11.
REQ-034 BTB is a separate sub-module, btb, parametrised by BTB_ENTRIES, with read port, write port and clear-index input.
REQ-035 Saturating-counter next-value logic is a package function shared by all three tables.

Verification
REQ-036 Release reset, defaults -> ready low exactly 256 cycles, then high; any lookup returns pred_taken=0, pred_target=pc+2.
REQ-037 Four updates taken, pc=0x3000, target=0x3040, ghist=0 -> lookup 0x3000 gives pred_taken=1, pred_target=0x3040, pred_local=1.
REQ-038 Counter at 11 plus two more taken updates -> stays 11; one not-taken -> 10, prediction still taken.
REQ-039 ghist=0x15, mispredict update with update_ghist=0x0A, update_taken=1, same-cycle lookup -> ghist=0x15 next cycle.
REQ-040 update_local=0, update_global=1, taken, twice -> chooser 01->10->11, pred_sel=1.
REQ-041 reset_n pulsed low for 1 cycle in RUN, asynchronous to clk -> ready drops immediately; BTB lookup 0x3000 misses after re-INIT.
